// File: rtl/alu_src_pkg.sv
// Shared constants for the ALU operand-B stage: lane numbers, forward codes, state type.
package alu_src_pkg;

    localparam int SRC_RD2   = 0;
    localparam int SRC_EXT   = 1;
    localparam int SRC_PC4   = 2;
    localparam int SRC_SHAMT = 3;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EM   = 2'b01;
    localparam logic [1:0] FWD_MW   = 2'b10;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

endpackage

// File: rtl/fwd_select.sv
// Lane-0 forwarding: the EM write beats the MW write; register 0 never forwards.
module fwd_select
    import alu_src_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int REGW  = 5
) (
    input  logic [REGW-1:0]  rt_addr_i,
    input  logic [WIDTH-1:0] lane0_i,
    input  logic             em_wr_en_i,
    input  logic [REGW-1:0]  em_wr_addr_i,
    input  logic [WIDTH-1:0] em_wr_data_i,
    input  logic             mw_wr_en_i,
    input  logic [REGW-1:0]  mw_wr_addr_i,
    input  logic [WIDTH-1:0] mw_wr_data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       hit_o
);

    // Priority compare: youngest pending write (EM) first, then MW, else register file value.
    always_comb begin
        data_o = lane0_i;
        hit_o  = FWD_NONE;
        if (rt_addr_i != '0) begin
            if (em_wr_en_i && (em_wr_addr_i == rt_addr_i)) begin
                data_o = em_wr_data_i;
                hit_o  = FWD_EM;
            end else if (mw_wr_en_i && (mw_wr_addr_i == rt_addr_i)) begin
                data_o = mw_wr_data_i;
                hit_o  = FWD_MW;
            end
        end
    end

endmodule

// File: rtl/alu_operand_b_stage.sv
// Operand-B source mux with lane-0 forwarding, captured in a one-entry valid/ready register.
module alu_operand_b_stage #(
    parameter  int WIDTH = 32,
    parameter  int NSRC  = 4,
    parameter  int REGW  = 5,
    localparam int SELW  = $clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SELW-1:0]       alu_src,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [REGW-1:0]       rt_addr,
    input  logic                  em_wr_en,
    input  logic [REGW-1:0]       em_wr_addr,
    input  logic [WIDTH-1:0]      em_wr_data,
    input  logic                  mw_wr_en,
    input  logic [REGW-1:0]       mw_wr_addr,
    input  logic [WIDTH-1:0]      mw_wr_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      alu_b,
    output logic [1:0]            fwd_hit
);

    import alu_src_pkg::*;

    logic [WIDTH-1:0] fwd_data;
    logic [1:0]       fwd_code;
    logic [WIDTH-1:0] mux_data;
    logic [1:0]       mux_hit;
    logic             load;
    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       hit_q, hit_d;

    fwd_select #(
        .WIDTH (WIDTH),
        .REGW  (REGW)
    ) u_fwd_select (
        .rt_addr_i    (rt_addr),
        .lane0_i      (src_data[WIDTH-1:0]),
        .em_wr_en_i   (em_wr_en),
        .em_wr_addr_i (em_wr_addr),
        .em_wr_data_i (em_wr_data),
        .mw_wr_en_i   (mw_wr_en),
        .mw_wr_addr_i (mw_wr_addr),
        .mw_wr_data_i (mw_wr_data),
        .data_o       (fwd_data),
        .hit_o        (fwd_code)
    );

    // Lane select; a select beyond the last lane yields zero with no forward.
    always_comb begin
        mux_data = '0;
        mux_hit  = FWD_NONE;
        if (alu_src == SELW'(SRC_RD2)) begin
            mux_data = fwd_data;
            mux_hit  = fwd_code;
        end else begin
            for (int i = 1; i < NSRC; i++) begin
                if (alu_src == SELW'(i)) begin
                    mux_data = src_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign load      = in_valid && in_ready && !flush;

    // Next state: flush wins over load and consume; otherwise load refills, consume drains.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (load) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // Payload only changes on an accepted load; drain and flush leave it as last loaded.
    always_comb begin
        alu_b_d = alu_b_q;
        hit_d   = hit_q;
        if (load) begin
            alu_b_d = mux_data;
            hit_d   = mux_hit;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand and forward-code registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_b_q <= '0;
            hit_q   <= FWD_NONE;
        end else begin
            alu_b_q <= alu_b_d;
            hit_q   <= hit_d;
        end
    end

    assign alu_b   = alu_b_q;
    assign fwd_hit = hit_q;

endmodule
